// File: rtl/ram_frame_sequencer_if.sv
// Bundle between stream source, frame sequencer and column-read RAM/consumer.
// Optional macro FRAME_COUNT_EN adds the frame_count observation signal.
interface ram_frame_sequencer_if #(
    parameter int SIZE = 16
);
    logic            start;
    logic            abort;
    logic            in_valid;
    logic [SIZE-1:0] in_data;
    logic            in_ready;
    logic            ram_wen;
    logic [2:0]      ram_wi;
    logic [2:0]      ram_wj;
    logic [SIZE-1:0] ram_wdata;
    logic [2:0]      ram_rj;
    logic            col_valid;
    logic            col_ready;
    logic            busy;
    logic            done;
`ifdef FRAME_COUNT_EN
    logic [7:0]      frame_count;

    modport slave (
        input  start, abort, in_valid, in_data, col_ready,
        output in_ready, ram_wen, ram_wi, ram_wj, ram_wdata, ram_rj,
               col_valid, busy, done, frame_count
    );

    modport master (
        output start, abort, in_valid, in_data, col_ready,
        input  in_ready, ram_wen, ram_wi, ram_wj, ram_wdata, ram_rj,
               col_valid, busy, done, frame_count
    );
`else
    modport slave (
        input  start, abort, in_valid, in_data, col_ready,
        output in_ready, ram_wen, ram_wi, ram_wj, ram_wdata, ram_rj,
               col_valid, busy, done
    );

    modport master (
        output start, abort, in_valid, in_data, col_ready,
        input  in_ready, ram_wen, ram_wi, ram_wj, ram_wdata, ram_rj,
               col_valid, busy, done
    );
`endif
endinterface

// File: rtl/ram_frame_sequencer.sv
// Loads one 64-word frame row-major into the 8x8 RAM, then steps the column-read address 0..7.
// Optional macro FRAME_COUNT_EN adds an 8-bit wrapping count of completed frames.
module ram_frame_sequencer #(
    parameter int SIZE = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    ram_frame_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_READ  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    state_e          state_q;
    logic [5:0]      wcnt_q;
    logic [2:0]      rj_q;
    logic            ram_wen_q;
    logic [2:0]      wi_q;
    logic [2:0]      wj_q;
    logic [SIZE-1:0] wdata_q;
    logic            in_ready_q;
    logic            col_valid_q;
    logic            busy_q;
    logic            done_q;
    logic            accept_s;
    logic            col_hs_s;
`ifdef FRAME_COUNT_EN
    logic [7:0]      frame_count_q;
`endif

    assign accept_s = bus.in_valid & in_ready_q;
    assign col_hs_s = col_valid_q & bus.col_ready;

    // Frame FSM; every output is a register updated here
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            wcnt_q      <= 6'd0;
            rj_q        <= 3'd0;
            ram_wen_q   <= 1'b0;
            wi_q        <= 3'd0;
            wj_q        <= 3'd0;
            wdata_q     <= '0;
            in_ready_q  <= 1'b0;
            col_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef FRAME_COUNT_EN
            frame_count_q <= 8'd0;
`endif
        end else if (bus.abort) begin
            // Abort beats start in IDLE and drops any write still pending
            state_q     <= ST_IDLE;
            wcnt_q      <= 6'd0;
            rj_q        <= 3'd0;
            ram_wen_q   <= 1'b0;
            in_ready_q  <= 1'b0;
            col_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            ram_wen_q <= 1'b0;
            done_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_q    <= ST_LOAD;
                        wcnt_q     <= 6'd0;
                        rj_q       <= 3'd0;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (accept_s) begin
                        ram_wen_q <= 1'b1;
                        wi_q      <= wcnt_q[5:3];
                        wj_q      <= wcnt_q[2:0];
                        wdata_q   <= bus.in_data;
                        if (wcnt_q == 6'd63) begin
                            state_q    <= ST_DRAIN;
                            in_ready_q <= 1'b0;
                        end else begin
                            wcnt_q <= wcnt_q + 6'd1;
                        end
                    end
                end
                ST_DRAIN: begin
                    state_q     <= ST_READ;
                    rj_q        <= 3'd0;
                    col_valid_q <= 1'b1;
                end
                ST_READ: begin
                    if (col_hs_s) begin
                        if (rj_q == 3'd7) begin
                            state_q     <= ST_DONE;
                            col_valid_q <= 1'b0;
                            done_q      <= 1'b1;
                        end else begin
                            rj_q <= rj_q + 3'd1;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
`ifdef FRAME_COUNT_EN
                    frame_count_q <= frame_count_q + 8'd1;
`endif
                end
                default: begin
                    state_q     <= ST_IDLE;
                    in_ready_q  <= 1'b0;
                    col_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.ram_wen   = ram_wen_q;
    assign bus.ram_wi    = wi_q;
    assign bus.ram_wj    = wj_q;
    assign bus.ram_wdata = wdata_q;
    assign bus.ram_rj    = rj_q;
    assign bus.col_valid = col_valid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
`ifdef FRAME_COUNT_EN
    assign bus.frame_count = frame_count_q;
`endif

endmodule

// File: tb/tb_ram_frame_sequencer.sv
// Self-checking bench for ram_frame_sequencer: randomized frames against a count-based frame model.
// Frame-count checks are compiled in when FRAME_COUNT_EN is defined.
module tb_ram_frame_sequencer;
    localparam int SIZE = 16;

    logic clock = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;
    int   exp_frames = 0;

    ram_frame_sequencer_if #(.SIZE(SIZE)) bus ();

    ram_frame_sequencer #(.SIZE(SIZE)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.col_ready = 1'b0;
    endtask

    function automatic logic [29:0] all_outs();
        return {bus.in_ready, bus.ram_wen, bus.ram_wi, bus.ram_wj, bus.ram_wdata,
                bus.ram_rj, bus.col_valid, bus.busy, bus.done};
    endfunction

    task automatic test_reset();
        logic [SIZE-1:0] d0;
        idle_inputs();
        reset_n = 1'b0;
        step();
        checks++;
        if (all_outs() !== 30'd0) begin
            errors++;
            $display("FAIL reset_outs: got %h expected 0", all_outs());
        end
`ifdef FRAME_COUNT_EN
        checks++;
        if (bus.frame_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_frame_count: got %0d expected 0", bus.frame_count);
        end
`endif
        reset_n = 1'b1;
        step();
        bus.start = 1'b1;
        step();
        bus.start    = 1'b0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.in_data = SIZE'($urandom);
            step();
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (all_outs() !== 30'd0) begin
            errors++;
            $display("FAIL async_reset_mid_load: got %h expected 0", all_outs());
        end
        step();
        reset_n      = 1'b1;
        exp_frames   = 0;
        d0           = SIZE'($urandom);
        bus.in_data  = d0;
        bus.start    = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        checks++;
        if ({bus.ram_wen, bus.ram_wi, bus.ram_wj, bus.ram_wdata} !== {1'b1, 3'd0, 3'd0, d0}) begin
            errors++;
            $display("FAIL restart_first_write: got wen=%0b wi=%0d wj=%0d d=%h expected 1 0 0 %h",
                     bus.ram_wen, bus.ram_wi, bus.ram_wj, bus.ram_wdata, d0);
        end
        bus.in_valid = 1'b0;
        bus.abort    = 1'b1;
        step();
        bus.abort = 1'b0;
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL restart_abort_idle: got busy=%0b expected 0", bus.busy);
        end
    endtask

    // mode 0: all ready, words 0..63; 1: in_valid toggles; 2: random + start in READ; 3: col stall at column 4
    task automatic run_frame(input int mode);
        logic [SIZE-1:0] words [64];
        int  nacc = 0, ncols = 0, tail = 0, after8 = 0, cyc = 0, hold = 0, nwrites = 0, prev_k = 0;
        bit  acc_prev = 1'b0, done_seen = 1'b0, start_pulsed = 1'b0;
        bit  exp_ir, exp_cv, exp_done, iv, cr, acc, hs;
        for (int i = 0; i < 64; i++) words[i] = (mode == 0) ? SIZE'(i) : SIZE'($urandom);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        cyc = 1;
        while (!done_seen && cyc < 400) begin
            exp_ir   = (nacc < 64);
            exp_cv   = (nacc == 64) && (tail >= 1) && (ncols < 8);
            exp_done = (ncols == 8) && (after8 == 0);
            checks++;
            if (bus.in_ready !== exp_ir) begin
                errors++;
                $display("FAIL in_ready m%0d c%0d: got %0b expected %0b", mode, cyc, bus.in_ready, exp_ir);
            end
            checks++;
            if (bus.ram_wen !== acc_prev) begin
                errors++;
                $display("FAIL ram_wen m%0d c%0d: got %0b expected %0b", mode, cyc, bus.ram_wen, acc_prev);
            end
            if (bus.ram_wen === 1'b1) nwrites++;
            if (acc_prev) begin
                checks++;
                if ({bus.ram_wi, bus.ram_wj, bus.ram_wdata} !== {3'(prev_k / 8), 3'(prev_k % 8), words[prev_k]}) begin
                    errors++;
                    $display("FAIL write_word m%0d k%0d: got wi=%0d wj=%0d d=%h expected %0d %0d %h", mode, prev_k,
                             bus.ram_wi, bus.ram_wj, bus.ram_wdata, prev_k / 8, prev_k % 8, words[prev_k]);
                end
                if (prev_k == 27) begin
                    checks++;
                    if ({bus.ram_wi, bus.ram_wj} !== {3'd3, 3'd3}) begin
                        errors++;
                        $display("FAIL word27_addr: got wi=%0d wj=%0d expected 3 3", bus.ram_wi, bus.ram_wj);
                    end
                end
            end
            checks++;
            if (bus.col_valid !== exp_cv) begin
                errors++;
                $display("FAIL col_valid m%0d c%0d: got %0b expected %0b", mode, cyc, bus.col_valid, exp_cv);
            end
            if (exp_cv) begin
                checks++;
                if (bus.ram_rj !== 3'(ncols)) begin
                    errors++;
                    $display("FAIL ram_rj m%0d c%0d: got %0d expected %0d", mode, cyc, bus.ram_rj, ncols);
                end
            end
            checks++;
            if (bus.done !== exp_done || bus.busy !== 1'b1) begin
                errors++;
                $display("FAIL done_busy m%0d c%0d: got done=%0b busy=%0b expected %0b 1",
                         mode, cyc, bus.done, bus.busy, exp_done);
            end
            if (exp_done) begin
                done_seen = 1'b1;
                if (mode == 0) begin
                    checks++;
                    if (cyc !== 74) begin
                        errors++;
                        $display("FAIL frame_latency: got %0d expected 74", cyc);
                    end
                end
            end
            iv = 1'b1;
            cr = 1'b1;
            bus.start = 1'b0;
            case (mode)
                1: iv = (cyc % 2 == 1);
                2: begin
                    iv = 1'($urandom_range(0, 1));
                    cr = 1'($urandom_range(0, 1));
                    if (exp_cv && ncols == 2 && !start_pulsed) begin
                        bus.start    = 1'b1;
                        start_pulsed = 1'b1;
                    end
                end
                3: begin
                    if (exp_cv && ncols == 4 && hold < 5) begin
                        cr = 1'b0;
                        hold++;
                    end
                end
                default: ;
            endcase
            bus.in_valid  = iv;
            bus.col_ready = cr;
            bus.in_data   = (nacc < 64) ? words[nacc] : SIZE'($urandom);
            acc = iv && exp_ir;
            hs  = cr && exp_cv;
            step();
            cyc++;
            if (nacc == 64) tail++;
            acc_prev = acc;
            if (acc) begin
                prev_k = nacc;
                nacc++;
            end
            if (ncols == 8) after8++;
            if (hs) ncols++;
        end
        idle_inputs();
        checks++;
        if (!done_seen) begin
            errors++;
            $display("FAIL frame_timeout m%0d: got no done within %0d cycles expected done", mode, cyc);
        end
        checks++;
        if (nwrites !== 64) begin
            errors++;
            $display("FAIL write_count m%0d: got %0d expected 64", mode, nwrites);
        end
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL post_frame_idle m%0d: got busy=%0b done=%0b expected 0 0", mode, bus.busy, bus.done);
        end
        if (mode == 3) begin
            checks++;
            if (hold !== 5) begin
                errors++;
                $display("FAIL col_stall_cycles: got %0d expected 5", hold);
            end
        end
        if (done_seen) exp_frames++;
`ifdef FRAME_COUNT_EN
        checks++;
        if (bus.frame_count !== exp_frames[7:0]) begin
            errors++;
            $display("FAIL frame_count m%0d: got %0d expected %0d", mode, bus.frame_count, exp_frames[7:0]);
        end
`endif
        step();
    endtask

    task automatic test_full_frame();
        run_frame(0);
    endtask

    task automatic test_toggle_valid();
        run_frame(1);
    endtask

    task automatic test_col_stall();
        run_frame(3);
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 3; f++) run_frame(2);
    endtask

    task automatic test_abort();
        logic [SIZE-1:0] last;
        bus.start = 1'b1;
        step();
        bus.start    = 1'b0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            last        = SIZE'($urandom);
            bus.in_data = last;
            step();
        end
        checks++;
        if ({bus.ram_wen, bus.ram_wi, bus.ram_wj, bus.ram_wdata} !== {1'b1, 3'd4, 3'd7, last}) begin
            errors++;
            $display("FAIL abort_prewrite: got wen=%0b wi=%0d wj=%0d d=%h expected 1 4 7 %h",
                     bus.ram_wen, bus.ram_wi, bus.ram_wj, bus.ram_wdata, last);
        end
        bus.in_data = SIZE'($urandom);
        bus.abort   = 1'b1;
        step();
        bus.abort    = 1'b0;
        bus.in_valid = 1'b0;
        checks++;
        if ({bus.busy, bus.ram_wen, bus.in_ready, bus.col_valid, bus.done} !== 5'd0) begin
            errors++;
            $display("FAIL abort_idle: got busy=%0b wen=%0b ir=%0b cv=%0b done=%0b expected all 0",
                     bus.busy, bus.ram_wen, bus.in_ready, bus.col_valid, bus.done);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (bus.done !== 1'b0 || bus.ram_wen !== 1'b0 || bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL abort_quiet c%0d: got done=%0b wen=%0b busy=%0b expected 0 0 0",
                         i, bus.done, bus.ram_wen, bus.busy);
            end
        end
        bus.start = 1'b1;
        bus.abort = 1'b1;
        step();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_beats_start: got busy=%0b expected 0", bus.busy);
        end
    endtask

`ifdef FRAME_COUNT_EN
    task automatic test_frame_count();
        reset_n = 1'b0;
        step();
        reset_n    = 1'b1;
        exp_frames = 0;
        for (int f = 0; f < 3; f++) run_frame(0);
        test_abort();
        checks++;
        if (bus.frame_count !== 8'd3) begin
            errors++;
            $display("FAIL frame_count_3: got %0d expected 3", bus.frame_count);
        end
        for (int f = 0; f < 252; f++) run_frame(0);
        checks++;
        if (bus.frame_count !== 8'd255) begin
            errors++;
            $display("FAIL frame_count_255: got %0d expected 255", bus.frame_count);
        end
        run_frame(0);
        checks++;
        if (bus.frame_count !== 8'd0) begin
            errors++;
            $display("FAIL frame_count_wrap: got %0d expected 0", bus.frame_count);
        end
    endtask
`endif

    initial begin
        reset_n = 1'b0;
        idle_inputs();
        test_reset();
        test_full_frame();
        test_toggle_valid();
        test_col_stall();
        test_random_frames();
        test_abort();
`ifdef FRAME_COUNT_EN
        test_frame_count();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
